// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target with 16-bit register addressing driving a register-file port
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR_P    = 7'h12,
  parameter int         SYNC_STAGES_P = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  output logic        wr_en_o,
  output logic [15:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic [15:0] rd_addr_o,
  input  logic [7:0]  rd_data_i,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_ADDR_ACK,
    S_REG_H,
    S_ACK_H,
    S_REG_L,
    S_ACK_L,
    S_WR_DATA,
    S_ACK_DATA,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  // Marker count in RD_ACK: master ACKed, reload the next byte on the coming SCL fall
  localparam logic [3:0] ACKED_CNT = 4'd9;

  logic [SYNC_STAGES_P-1:0] scl_sync_q, sda_sync_q;
  logic                     scl_d_q, sda_d_q;
  logic                     scl_s, sda_s;
  logic                     scl_rise, scl_fall, start_evt, stop_evt;
  logic [7:0]               byte_in;

  state_t      state_q, state_n;
  logic [3:0]  bit_cnt_q, bit_cnt_n;
  logic [7:0]  shift_q, shift_n;
  logic [7:0]  tx_q, tx_n;
  logic [15:0] reg_addr_q, reg_addr_n;
  logic        sda_oe_q, sda_oe_n;
  logic        busy_q, busy_n;
  logic        wr_en_q, wr_en_n;
  logic [15:0] wr_addr_q, wr_addr_n;
  logic [7:0]  wr_data_q, wr_data_n;

  // Pad synchronizers plus one delayed copy for edge detection; idle bus level is high
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_d_q    <= 1'b1;
      sda_d_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES_P-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES_P-2:0], sda_i};
      scl_d_q    <= scl_s;
      sda_d_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES_P-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES_P-1];
  assign scl_rise  = scl_s & ~scl_d_q;
  assign scl_fall  = ~scl_s & scl_d_q;
  assign start_evt = scl_s & scl_d_q & sda_d_q & ~sda_s;
  assign stop_evt  = scl_s & scl_d_q & ~sda_d_q & sda_s;
  assign byte_in   = {shift_q[6:0], sda_s};

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      reg_addr_q <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      shift_q    <= shift_n;
      tx_q       <= tx_n;
      reg_addr_q <= reg_addr_n;
      sda_oe_q   <= sda_oe_n;
      busy_q     <= busy_n;
      wr_en_q    <= wr_en_n;
      wr_addr_q  <= wr_addr_n;
      wr_data_q  <= wr_data_n;
    end
  end

  // Bus protocol: STOP beats START beats per-state bit handling; SDA only changes after SCL falls
  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    shift_n    = shift_q;
    tx_n       = tx_q;
    reg_addr_n = reg_addr_q;
    sda_oe_n   = sda_oe_q;
    busy_n     = busy_q;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr_q;
    wr_data_n  = wr_data_q;

    if (stop_evt) begin
      state_n  = S_IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_evt) begin
      state_n   = S_DEV_ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else begin
      case (state_q)
        S_DEV_ADDR, S_REG_H, S_REG_L, S_WR_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_n   = byte_in;
            bit_cnt_n = bit_cnt_q + 4'd1;
            if (state_q == S_WR_DATA && bit_cnt_q == 4'd7) begin
              wr_en_n    = 1'b1;
              wr_addr_n  = reg_addr_q;
              wr_data_n  = byte_in;
              reg_addr_n = reg_addr_q + 16'd1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_n = 1'b1;
            if (state_q == S_DEV_ADDR) begin
              if (shift_q[7:1] == DEV_ADDR_P) begin
                state_n = S_ADDR_ACK;
                busy_n  = 1'b1;
              end else begin
                state_n  = S_IGNORE;
                sda_oe_n = 1'b0;
                busy_n   = 1'b0;
              end
            end else if (state_q == S_REG_H) begin
              reg_addr_n[15:8] = shift_q;
              state_n          = S_ACK_H;
            end else if (state_q == S_REG_L) begin
              reg_addr_n[7:0] = shift_q;
              state_n         = S_ACK_L;
            end else begin
              state_n = S_ACK_DATA;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = '0;
            if (shift_q[0]) begin
              state_n  = S_RD_DATA;
              tx_n     = rd_data_i;
              sda_oe_n = ~rd_data_i[7];
            end else begin
              state_n  = S_REG_H;
              sda_oe_n = 1'b0;
            end
          end
        end
        S_ACK_H, S_ACK_L, S_ACK_DATA: begin
          if (scl_fall) begin
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            state_n   = (state_q == S_ACK_H) ? S_REG_L : S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_n = 1'b0;
              state_n  = S_RD_ACK;
            end else begin
              tx_n     = {tx_q[6:0], 1'b0};
              sda_oe_n = ~tx_q[6];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              reg_addr_n = reg_addr_q + 16'd1;
              bit_cnt_n  = ACKED_CNT;
            end else begin
              state_n = S_IGNORE;
            end
          end else if (scl_fall && bit_cnt_q == ACKED_CNT) begin
            state_n   = S_RD_DATA;
            bit_cnt_n = '0;
            tx_n      = rd_data_i;
            sda_oe_n  = ~rd_data_i[7];
          end
        end
        default: begin
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe_o  = sda_oe_q;
  assign busy_o    = busy_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign rd_addr_o = reg_addr_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - randomized I2C master bench with transaction-level target model
`timescale 1ns/1ps
module tb_i2c_target_regfile;

  typedef logic [7:0] q8_t[$];

  localparam logic [6:0] DEV = 7'h12;
  localparam int         Q   = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl_m, sda_m;
  wire         sda_bus;
  logic        sda_oe_o, wr_en_o, busy_o;
  logic [15:0] wr_addr_o, rd_addr_o;
  logic [7:0]  wr_data_o, rd_data_i;
  logic [7:0]  rd_key;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [15:0] m_addr;
  logic        exp_busy, exp_oe, chk_en;
  logic [23:0] exp_wr[$];
  logic [23:0] got_wr[$];
  logic        oe_prev, scl_prev, rst_prev;

  always #5 clk = ~clk;

  assign sda_bus   = sda_m & ~sda_oe_o;
  assign rd_data_i = rd_addr_o[7:0] + rd_key;

  i2c_target_regfile #(.DEV_ADDR_P(7'h12), .SYNC_STAGES_P(2)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_oe_o(sda_oe_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .busy_o(busy_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en_o) begin
        logic [24:0] e;
        e = (exp_wr.size() > 0) ? {1'b1, exp_wr.pop_front()} : 25'h0;
        got_wr.push_back({wr_addr_o, wr_data_o});
        chk("wr_event", {7'd0, 1'b1, wr_addr_o, wr_data_o}, {7'd0, e});
      end
      if (chk_en) begin
        chk("sda_oe", {31'd0, sda_oe_o}, {31'd0, exp_oe});
        chk("busy", {31'd0, busy_o}, {31'd0, exp_busy});
      end
      if (scl_m && scl_prev && !rst_prev)
        chk("oe_stable_scl_high", {31'd0, sda_oe_o}, {31'd0, oe_prev});
    end
    oe_prev  = sda_oe_o;
    scl_prev = scl_m;
    rst_prev = rst;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic bit_xfer(input logic b, input logic eoe, output logic s);
    repeat (Q) @(posedge clk);
    sda_m = b;
    repeat (Q) @(posedge clk);
    scl_m = 1'b1;
    exp_oe = eoe;
    chk_en = 1'b1;
    repeat (Q) @(posedge clk);
    s = sda_bus;
    repeat (Q) @(posedge clk);
    chk_en = 1'b0;
    scl_m = 1'b0;
  endtask

  task automatic start_cond();
    repeat (Q) @(posedge clk);
    sda_m = 1'b1;
    repeat (Q) @(posedge clk);
    scl_m = 1'b1;
    repeat (Q) @(posedge clk);
    sda_m = 1'b0;
    repeat (Q) @(posedge clk);
    scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    repeat (Q) @(posedge clk);
    sda_m = 1'b0;
    repeat (Q) @(posedge clk);
    scl_m = 1'b1;
    repeat (Q) @(posedge clk);
    sda_m = 1'b1;
    repeat (2 * Q) @(posedge clk);
    exp_busy = 1'b0;
    exp_oe   = 1'b0;
    chk_en   = 1'b1;
    @(posedge clk);
    chk_en   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic eack, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], 1'b0, s);
    bit_xfer(1'b1, eack, s);
    ack = ~s;
  endtask

  task automatic addr_phase(input logic [7:0] dev, output logic match, output logic ack);
    logic s;
    match = (dev[7:1] == DEV);
    for (int i = 7; i >= 0; i--) bit_xfer(dev[i], 1'b0, s);
    exp_busy = match;
    bit_xfer(1'b1, match, s);
    ack = ~s;
  endtask

  // Write transaction: byte 0/1 set the register address, later bytes are burst writes
  task automatic write_txn(input logic [7:0] dev, input q8_t data, input int cut,
                           input logic do_stop, output logic [15:0] acks);
    logic match, a, s;
    logic [7:0] cb;
    acks = '0;
    start_cond();
    addr_phase(dev, match, a);
    acks[0] = a;
    for (int k = 0; k < data.size(); k++) begin
      if (match && k >= 2) begin
        exp_wr.push_back({m_addr, data[k]});
        m_addr = m_addr + 16'd1;
      end
      send_byte(data[k], match, a);
      acks[k+1] = a;
      if (match && k == 0) m_addr[15:8] = data[k];
      if (match && k == 1) m_addr[7:0]  = data[k];
    end
    if (cut > 0) begin
      cb = 8'($urandom);
      for (int i = 0; i < cut; i++) bit_xfer(cb[7-i], 1'b0, s);
    end
    if (do_stop) begin
      stop_cond();
      chk("wr_all_done", exp_wr.size(), 0);
    end
  endtask

  // Read transaction from the current register address; last byte NACKed
  task automatic read_txn(input int n, output q8_t got);
    logic match, a, s, ma;
    logic [7:0] ed, g;
    got.delete();
    start_cond();
    addr_phase({DEV, 1'b1}, match, a);
    chk("rd_addr_ack", {31'd0, a}, 32'd1);
    for (int i = 0; i < n; i++) begin
      ed = m_addr[7:0] + rd_key;
      ma = (i < n - 1);
      for (int j = 7; j >= 0; j--) begin
        bit_xfer(1'b1, ~ed[j], s);
        g[j] = s;
      end
      bit_xfer(~ma, 1'b0, s);
      got.push_back(g);
      if (ma) m_addr = m_addr + 16'd1;
    end
    stop_cond();
  endtask

  initial begin
    logic [15:0] acks;
    q8_t         q, got;
    int          kind, n, cut;
    logic [6:0]  a7;
    logic        s;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rd_key = 8'h00;
    m_addr = 16'h0; exp_busy = 1'b0; exp_oe = 1'b0; chk_en = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_sda_oe", {31'd0, sda_oe_o}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
    chk("rst_wr_addr", {16'd0, wr_addr_o}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data_o}, 32'd0);
    chk("rst_rd_addr", {16'd0, rd_addr_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    @(posedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // 1: simple register write
    got_wr.delete();
    q = '{8'h01, 8'h03, 8'h01};
    write_txn(8'h24, q, 0, 1'b1, acks);
    chk("t1_acks", {16'd0, acks}, 32'h0000_000F);
    chk("t1_wr_count", got_wr.size(), 1);
    if (got_wr.size() > 0) chk("t1_wr", {8'd0, got_wr[0]}, 32'h0001_0301);

    // 2: foreign address ignored
    got_wr.delete();
    q = '{8'h05, 8'h06, 8'h07};
    write_txn(8'h30, q, 0, 1'b1, acks);
    chk("t2_acks", {16'd0, acks}, 32'h0);
    chk("t2_wr_count", got_wr.size(), 0);
    chk("t2_busy", {31'd0, busy_o}, 32'd0);

    // 3: burst write across address wrap
    got_wr.delete();
    q = '{8'hFF, 8'hFF, 8'hAA, 8'h55};
    write_txn(8'h24, q, 0, 1'b1, acks);
    chk("t3_wr_count", got_wr.size(), 2);
    if (got_wr.size() > 1) begin
      chk("t3_wr0", {8'd0, got_wr[0]}, 32'h00FF_FFAA);
      chk("t3_wr1", {8'd0, got_wr[1]}, 32'h0000_0055);
    end

    // 4: set address, repeated START, read two bytes
    rd_key = 8'h00;
    q = '{8'h03, 8'h40};
    write_txn(8'h24, q, 0, 1'b0, acks);
    read_txn(2, got);
    chk("t4_rd_count", got.size(), 2);
    if (got.size() > 1) begin
      chk("t4_rd0", {24'd0, got[0]}, 32'h40);
      chk("t4_rd1", {24'd0, got[1]}, 32'h41);
    end
    chk("t4_busy_after_stop", {31'd0, busy_o}, 32'd0);

    // 5: STOP in the middle of a data byte discards it
    got_wr.delete();
    q = '{8'h22, 8'h33};
    write_txn(8'h24, q, 4, 1'b1, acks);
    chk("t5_partial_no_wr", got_wr.size(), 0);
    q = '{8'h01, 8'h00, 8'h04};
    write_txn(8'h24, q, 0, 1'b1, acks);
    chk("t5_wr_count", got_wr.size(), 1);
    if (got_wr.size() > 0) chk("t5_wr", {8'd0, got_wr[0]}, 32'h0001_0004);

    // 6: reset while the address ACK is being driven
    start_cond();
    for (int i = 7; i >= 0; i--) bit_xfer(q[0][i] ^ q[0][i] ^ 1'(8'h24 >> i), 1'b0, s);
    repeat (Q + 1) @(posedge clk);
    @(negedge clk);
    chk("t6_oe_before_rst", {31'd0, sda_oe_o}, 32'd1);
    chk("t6_busy_before_rst", {31'd0, busy_o}, 32'd1);
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_oe_after_rst", {31'd0, sda_oe_o}, 32'd0);
    chk("t6_busy_after_rst", {31'd0, busy_o}, 32'd0);
    @(posedge clk);
    rst = 1'b0;
    m_addr = 16'h0; exp_busy = 1'b0; exp_wr.delete();
    stop_cond();
    got_wr.delete();
    q = '{8'h00, 8'h10, 8'h77};
    write_txn(8'h24, q, 0, 1'b1, acks);
    chk("t6_acks", {16'd0, acks}, 32'h0000_000F);
    if (got_wr.size() > 0) chk("t6_wr", {8'd0, got_wr[0]}, 32'h0000_1077);

    // Randomized traffic against the model
    for (int it = 0; it < 24; it++) begin
      rd_key = 8'($urandom);
      kind = int'($urandom_range(0, 3));
      q.delete();
      case (kind)
        0: begin
          n = int'($urandom_range(0, 4));
          for (int k = 0; k < n; k++) q.push_back(8'($urandom));
          cut = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
          write_txn(8'h24, q, cut, 1'b1, acks);
        end
        1: begin
          do a7 = 7'($urandom); while (a7 == DEV);
          n = int'($urandom_range(0, 3));
          for (int k = 0; k < n; k++) q.push_back(8'($urandom));
          write_txn({a7, 1'($urandom)}, q, 0, 1'b1, acks);
        end
        2: begin
          q.push_back(($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom));
          q.push_back(8'($urandom));
          write_txn(8'h24, q, 0, 1'b0, acks);
          read_txn(int'($urandom_range(1, 3)), got);
        end
        default: begin
          read_txn(int'($urandom_range(1, 3)), got);
        end
      endcase
    end

    repeat (10) @(posedge clk);
    chk("final_wr_queue_empty", exp_wr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
